// File: rtl/redmule_x_pingpong_if.sv
// hwpe_stream_intf_stream: valid/ready stream bundle carrying X beats from the streamer.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  modport sink (input valid, data, strb, output ready);
  modport source (output valid, data, strb, input ready);
endinterface

// File: rtl/redmule_x_pingpong.sv
// redmule_x_pingpong: double-buffered X tile buffer between streamer and engine.
// Define REDMULE_XBUF_PERF_EN to enable the saturating backpressure counter on stall_cnt_o.
module redmule_x_pingpong #(
  parameter int unsigned DW    = 288,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW_L  = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  hwpe_stream_intf_stream.sink x_stream_i,
  input  logic [AW_L:0]        tile_len_i,
  input  logic                 rd_en_i,
  input  logic [AW_L-1:0]      rd_addr_i,
  input  logic                 tile_release_i,
  output logic                 tile_valid_o,
  output logic [DW-1:0]        rd_data_o,
  output logic                 rd_valid_o,
  output logic [1:0]           banks_full_o,
  output logic [15:0]          stall_cnt_o
);
  localparam logic [AW_L:0] LMAX = (AW_L+1)'(DEPTH);
  localparam logic [AW_L:0] ONE  = (AW_L+1)'(1);
  logic [DW-1:0] mem [2][DEPTH];
  logic [1:0]    full, full_n;
  logic          wsel, rsel, hs, last, rel, rd_hit;
  logic [AW_L:0] wcnt, len_q, len_c, len_e;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  assign x_stream_i.ready = enable_i && !full[wsel];
  assign hs     = x_stream_i.valid && x_stream_i.ready;
  assign len_c  = tile_len_i == '0 ? ONE : tile_len_i > LMAX ? LMAX : tile_len_i;
  assign len_e  = wcnt == '0 ? len_c : len_q;
  assign last   = wcnt == len_e - ONE;
  assign rel    = tile_release_i && full[rsel];
  assign rd_hit = rd_en_i && full[rsel];

  // Fill and release always hit different banks, so both updates can apply together.
  always_comb begin
    full_n = full;
    if (hs && last) full_n[wsel] = 1'b1;
    if (rel) full_n[rsel] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full       <= '0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wcnt       <= '0;
      len_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (clear_i) begin
      full       <= '0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wcnt       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      full       <= full_n;
      rsel       <= rel ? ~rsel : rsel;
      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= mem[rsel][rd_addr_i];
      if (hs) begin
        if (wcnt == '0) len_q <= len_c;
        wsel <= last ? ~wsel : wsel;
        wcnt <= last ? '0 : wcnt + ONE;
      end
    end
  end

  // Storage is not reset; clear leaves contents in place.
  always_ff @(posedge clk_i) begin
    if (hs && !clear_i) mem[wsel][wcnt[AW_L-1:0]] <= x_stream_i.data;
  end

`ifdef REDMULE_XBUF_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else if (clear_i) stall_q <= '0;
    else if (x_stream_i.valid && !x_stream_i.ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign tile_valid_o = full[rsel];
  assign banks_full_o = full;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
endmodule

// File: tb/tb_redmule_x_pingpong.sv
// tb_redmule_x_pingpong: directed and random stimulus against a tile-queue reference model.
module tb_redmule_x_pingpong;
  localparam int DW = 288, DEPTH = 4, AW = 2;
  logic clk = 0, rst_n = 1, clr = 0, en = 1, re = 0, rel = 0;
  logic [AW:0] tl = '0;
  logic [AW-1:0] ra = '0;
  logic tv, rv;
  logic [DW-1:0] rd;
  logic [1:0] bf;
  logic [15:0] sc;
  int vectors = 0, miscompares = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) xs ();

  redmule_x_pingpong #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en), .x_stream_i(xs),
    .tile_len_i(tl), .rd_en_i(re), .rd_addr_i(ra), .tile_release_i(rel),
    .tile_valid_o(tv), .rd_data_o(rd), .rd_valid_o(rv), .banks_full_o(bf), .stall_cnt_o(sc)
  );

  always #5 clk = ~clk;

  // Reference model: completed tiles in arrival order, plus the tile being collected.
  logic [DEPTH*DW-1:0] tile_d[$];
  int tile_len[$];
  bit tile_bank[$];
  logic [DW-1:0] part[$];
  int plen, stall;
  bit wbank, m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int t);
    return t == 0 ? 1 : t > DEPTH ? DEPTH : t;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW/32; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [1:0] exp_bf();
    logic [1:0] b = '0;
    foreach (tile_bank[i]) b[tile_bank[i]] = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    tile_d.delete(); tile_len.delete(); tile_bank.delete(); part.delete();
    wbank = 0; stall = 0; m_rv = 0;
  endtask

  task automatic post_chk();
    chk("tile_valid", tv, tile_d.size() > 0);
    chk("banks_full", bf, exp_bf());
    chk("rd_valid", rv, m_rv);
    chk("rd_data", rd, m_rd);
`ifdef REDMULE_XBUF_PERF_EN
    chk("stall_cnt", sc, stall);
`else
    chk("stall_cnt", sc, 0);
`endif
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input int len, input bit r,
                     input int a, input bit rl, input bit c, output bit acc);
    bit rdy, valid_t;
    logic [DEPTH*DW-1:0] t;
    @(negedge clk);
    xs.valid = v; xs.data = d; xs.strb = '1;
    tl = len[AW:0]; re = r; ra = a[AW-1:0]; rel = rl; clr = c;
    rdy = en && tile_d.size() < 2;
    #1 chk("ready", xs.ready, rdy);
    acc = v && rdy && !c;
    @(posedge clk);
    if (c) model_clear();
    else begin
      valid_t = tile_d.size() > 0;
      m_rv = r && valid_t;
      if (m_rv) m_rd = tile_d[0][a*DW +: DW];
      if (v && !rdy && stall < 65535) stall++;
      if (rl && valid_t) begin
        void'(tile_d.pop_front()); void'(tile_len.pop_front()); void'(tile_bank.pop_front());
      end
      if (v && rdy) begin
        if (part.size() == 0) plen = clamp(len);
        part.push_back(d);
        if (part.size() == plen) begin
          t = '0;
          foreach (part[i]) t[i*DW +: DW] = part[i];
          tile_d.push_back(t); tile_len.push_back(plen); tile_bank.push_back(wbank);
          wbank = !wbank;
          part.delete();
        end
      end
    end
    #1 post_chk();
  endtask

  task automatic idle(input bit rl);
    bit acc;
    cyc(0, '0, 4, 0, 0, rl, 0, acc);
  endtask

  task automatic async_reset_check();
    chk("rst_tile_valid", tv, 0);
    chk("rst_rd_valid", rv, 0);
    chk("rst_rd_data", rd, 0);
    chk("rst_banks_full", bf, 0);
    chk("rst_stall_cnt", sc, 0);
    chk("rst_ready", xs.ready, en);
  endtask

  initial begin
    bit acc;
    int b, a;
    xs.valid = 0; xs.data = '0; xs.strb = '0;
    m_rd = '0; plen = 1;
    model_clear();
    #1 rst_n = 0;
    #1 async_reset_check();
    @(negedge clk); rst_n = 1;

    // Single tile of four beats, then read it back line by line.
    for (int i = 0; i < 4; i++) cyc(1, DW'('hA0 + i), 4, 0, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++) cyc(0, '0, 4, 1, i, 0, 0, acc);
    idle(1);

    // Twelve beats with no release until both banks have stalled for a while.
    b = 0;
    for (int c = 0; c < 24 && b < 12; c++) begin
      cyc(1, DW'('hC0 + b), 4, 0, 0, c == 13, 0, acc);
      if (acc) b++;
    end
    if (b != 12) chk("burst_done", b, 12);
    for (int i = 0; i < 4; i++) cyc(0, '0, 4, 1, i, 0, 0, acc);
    idle(1); idle(1); idle(1);

    // Last beat of one bank lands together with the release of the other.
    for (int i = 0; i < 7; i++) cyc(1, rnd(), 4, 0, 0, 0, 0, acc);
    cyc(1, rnd(), 4, 1, 2, 1, 0, acc);
    for (int i = 0; i < 4; i++) cyc(0, '0, 4, 1, i, 0, 0, acc);
    idle(1); idle(1);

    // Length clamping: zero means one beat, oversize means DEPTH; later length changes ignored.
    cyc(1, DW'('hD0), 0, 0, 0, 0, 0, acc);
    cyc(1, DW'('hD1), 7, 0, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) cyc(1, DW'('hD2 + i), 1, 0, 0, 0, 0, acc);
    cyc(0, '0, 4, 1, 0, 1, 0, acc);
    for (int i = 0; i < 4; i++) cyc(0, '0, 4, 1, i, 0, 0, acc);
    idle(1);

    // Release with nothing valid, clear mid-tile, then a fresh tile.
    idle(1);
    cyc(1, rnd(), 4, 0, 0, 0, 0, acc);
    cyc(1, rnd(), 4, 0, 0, 0, 0, acc);
    cyc(0, '0, 4, 0, 0, 0, 1, acc);
    for (int i = 0; i < 4; i++) cyc(1, DW'('hB0 + i), 4, 0, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++) cyc(0, '0, 4, 1, i, 0, 0, acc);

    // Asynchronous reset in the middle of a fill.
    cyc(1, rnd(), 4, 0, 0, 0, 0, acc);
    cyc(1, rnd(), 4, 0, 0, 0, 0, acc);
    @(negedge clk); #2 rst_n = 0;
    #1 async_reset_check();
    model_clear(); m_rd = '0;
    xs.valid = 0;
    @(negedge clk); rst_n = 1;
    idle(0);

    for (int k = 0; k < 500; k++) begin
      en = $urandom_range(0, 7) != 0;
      a = tile_d.size() > 0 ? $urandom_range(0, tile_len[0] - 1) : $urandom_range(0, 3);
      cyc($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 7), $urandom_range(0, 1), a,
          $urandom_range(0, 4) == 0, $urandom_range(0, 80) == 0, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/redmule_x_pingpong.md
# redmule_x_pingpong

- Double-buffered (ping-pong) tile buffer directly downstream of the streamer's X stream output.
- Collects DW-wide X beats into one of two banks. Once a bank holds a complete tile, it exposes it to the engine for random-access reads.
- The second bank fills in parallel, so streamer memory traffic overlaps engine compute.

## Interface
Parameters:
- DW, 288, stream / bank line width in bits
- DEPTH, 4, lines per bank (max beats per tile); power of two, ≥2
- AW_L, $clog2(DEPTH), line address width (derived)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all control state
- enable_i  in  1  gates stream acceptance
- x_stream_i  hwpe_stream_intf_stream.sink  DW  X beats from streamer; strb ignored
- tile_len_i  in  AW_L+1  beats per tile; sampled on first beat of each tile
- rd_en_i  in  1  engine line read request
- rd_addr_i  in  AW_L  line index within current read bank
- tile_release_i  in  1  engine done with current read bank
- tile_valid_o  out  1  read bank holds a complete tile
- rd_data_o  out  DW  registered read data
- rd_valid_o  out  1  rd_data_o valid
- banks_full_o  out  2  full flag per bank
- stall_cnt_o  out  16  backpressure cycle count (see Configuration)

## Operation
State:
- mem[2][DEPTH]
- full[1:0]
- wsel, rsel: bank pointers
- wcnt: AW_L+1 bits
- len_q
- rd_data_q, rd_valid_q

Write side:
- x_stream_i.ready = enable_i && !full[wsel]. Purely combinational; no dependence on valid.
- Handshake (valid && ready):
  - mem[wsel][wcnt] <= data.
  - If wcnt==0, len_q <= clamp(tile_len_i).
  - The effective length L is the clamped value when wcnt==0, and len_q otherwise.
  - If wcnt==L-1: full[wsel]<=1, wsel toggles, wcnt<=0. Otherwise wcnt++.
- Clamp rule: 0 → 1; values > DEPTH → DEPTH.

Read side:
- tile_valid_o = full[rsel].
- rd_en_i && tile_valid_o: rd_data_q <= mem[rsel][rd_addr_i], rd_valid_q <= 1. Otherwise rd_valid_q <= 0 and rd_data_q holds.
- rd_addr_i ≥ len_q of that tile returns stale contents. No error is flagged.
- tile_release_i && tile_valid_o: full[rsel]<=0, rsel toggles.
- tile_release_i while !tile_valid_o is ignored.

Boundary conditions:
- Both banks full: ready=0 until a release. Ready returns in the cycle after the release.
- Last-beat write and release in the same cycle: they target different banks and both take effect.
- rd_en_i and tile_release_i in the same cycle: the read uses the pre-release rsel. Data appears the next cycle even though tile_valid_o may have dropped.
- Write into bank B never occurs while full[B]=1, so there are no read/write collisions on a bank.
- clear_i: full, wsel, rsel, wcnt, rd_valid_q, stall counter ← 0. Memory contents are retained. clear_i dominates all same-cycle events.
- Reset mid-tile: partial tile is discarded; same state as clear.

## Timing
- Reset values:
  - tile_valid_o=0, rd_valid_o=0, rd_data_o=0, banks_full_o=0, stall_cnt_o=0.
  - x_stream_i.ready=enable_i.
- Fill latency: tile_valid_o rises 1 cycle after the last-beat handshake.
- Read latency: 1 cycle (rd_en_i at cycle n → rd_valid_o and rd_data_o at n+1).
- Sustained throughput: 1 beat/cycle in, 1 line/cycle out.
- Release to reuse: a released bank accepts a write the cycle after the release.

## Configuration
- REDMULE_XBUF_PERF_EN defined:
  - stall_cnt_o is a 16-bit saturating counter.
  - It increments each cycle with x_stream_i.valid && !x_stream_i.ready.
  - It holds at 16'hFFFF.
  - It is cleared by reset and clear_i.
- Not defined: stall_cnt_o tied to 0; no counter logic.

## Test plan
1. DEPTH=4, tile_len_i=4, 4 back-to-back beats 0xA0..0xA3:
   - tile_valid_o=1 the cycle after the 4th beat; banks_full_o=2'b01.
   - Reads of addr 0..3 return 0xA0..0xA3 with 1-cycle latency.
2. Stream 12 beats continuously with no release:
   - ready drops after beat 8; banks_full_o=2'b11.
   - With PERF_EN, stall_cnt_o counts the stalled cycles (e.g. 5 → 5).
   - A release restores ready the next cycle, and beats 9–12 land in bank 0.
3. Write last beat of bank 1 in the same cycle as releasing bank 0:
   - Next cycle: banks_full_o=2'b10, rsel=1, tile_valid_o=1.
4. tile_len_i=0, then tile_len_i=7 (DEPTH=4):
   - First tile completes after 1 beat; second tile completes after 4 beats.
   - tile_len_i changes mid-tile have no effect.
5. Assert clear_i after 2 of 4 beats, then send 4 new beats 0xB0..0xB3:
   - Tile completes in bank 0; reads return 0xB0..0xB3.
   - tile_release_i with tile_valid_o=0 leaves state unchanged.
6. Deassert rst_ni asynchronously mid-fill:
   - All outputs return to reset values immediately, without waiting for a clock edge.
   - After reset release, ready equals enable_i.
